axi_mem_responder: RTL and testbench

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder
Interface
REQ-001 SHALL have parameter MEM_BYTES, default 65536, backing-store size in bytes at base 0; a power of two, minimum 64.
REQ-002 SHALL have parameter READ_LATENCY, default 4, cycles from AR accept to first RVALID; minimum 1.
REQ-003 SHALL have port clk  input  1  clock clk.
REQ-004 SHALL have port reset  input  1  reset reset, synchronous, active-high.
REQ-005 SHALL have port m_axi_awid  input  13  write burst ID.
REQ-006 SHALL have port m_axi_awaddr  input  64  write start byte address.
REQ-007 SHALL have port m_axi_awlen  input  8  write beats minus 1.
REQ-008 SHALL have port m_axi_awvalid  input  1  AW valid.
REQ-009 SHALL have port m_axi_awready  output  1  AW ready.
REQ-010 SHALL have port m_axi_wdata  input  64  write beat data.
REQ-011 SHALL have port m_axi_wstrb  input  8  byte enables.
REQ-012 SHALL have port m_axi_wlast  input  1  final write beat.
REQ-013 SHALL have port m_axi_wvalid  input  1  W valid.
REQ-014 SHALL have port m_axi_wready  output  1  W ready.
REQ-015 SHALL have port m_axi_bid  output  13  echoed AWID.
REQ-016 SHALL have port m_axi_bresp  output  2  00 OKAY, 10 SLVERR.
REQ-017 SHALL have port m_axi_bvalid  output  1  B valid.
REQ-018 SHALL have port m_axi_bready  input  1  B ready.
REQ-019 SHALL have port m_axi_arid  input  13  read burst ID.
REQ-020 SHALL have port m_axi_araddr  input  64  read start (critical-word) byte address.
REQ-021 SHALL have port m_axi_arlen  input  8  read beats minus 1.
REQ-022 SHALL have port m_axi_arburst  input  2  01 INCR, 10 WRAP.
REQ-023 SHALL have port m_axi_arvalid  input  1  AR valid.
REQ-024 SHALL have port m_axi_arready  output  1  AR ready.
REQ-025 SHALL have port m_axi_rid  output  13  echoed ARID.
REQ-026 SHALL have port m_axi_rdata  output  64  read beat data.
REQ-027 SHALL have port m_axi_rresp  output  2  00 OKAY, 10 SLVERR.
REQ-028 SHALL have port m_axi_rlast  output  1  final read beat.
REQ-029 SHALL have port m_axi_rvalid  output  1  R valid.
REQ-030 SHALL have port m_axi_rready  input  1  R ready.
REQ-031 SHALL have port m_axi_acvalid  output  1  snoop request valid.
REQ-032 SHALL have port m_axi_acready  input  1  snoop accepted; a constant 1 is legal.
REQ-033 SHALL have port m_axi_acaddr  output  64  64-byte-aligned line address of the snoop.
REQ-034 SHALL have port m_axi_acsnoop  output  4  snoop type, always 4'hD (MakeInvalid).
Function
REQ-035 SHALL use 8-byte beats only: beat address low 3 bits ignored; write beats INCR only.
REQ-036 Read FSM SHALL use states R_IDLE, R_WAIT, R_BURST; arready=1 only in R_IDLE; AR accept latches ID, address, length, burst; R_WAIT counts READ_LATENCY cycles, then R_BURST.
REQ-037 R_BURST SHALL hold rvalid with stable rid/rdata/rresp/rlast until rready; advance the beat on rvalid&&rready; rlast on beat arlen; after the last beat, R_IDLE the next cycle.
REQ-038 WRAP beat address SHALL be (start & ~(len_bytes-1)) | ((start+8*i) & (len_bytes-1)), where len_bytes = 8*(arlen+1); e.g. arlen 7 at 0x1038 gives 0x1038, 0x1000, ..., 0x1030. INCR beat address SHALL be start+8*i.
REQ-039 Write FSM SHALL use states W_IDLE, W_DATA, W_RESP, W_SNOOP; awready=1 only in W_IDLE; wready=1 only in W_DATA; each accepted beat commits the strobed bytes in the same cycle.
REQ-040 On accepting the wlast beat, the write FSM SHALL enter W_RESP; wlast is trusted, with no awlen beat-count check. B SHALL hold until bready, then enter W_SNOOP and assert acvalid with the line of awaddr until acready, then return to W_IDLE.
REQ-041 An out-of-range beat address (>= MEM_BYTES) SHALL return rdata 0 and rresp SLVERR without wrapping; an out-of-range write beat SHALL be dropped and the burst's bresp SHALL be SLVERR.
REQ-042 Read and write FSMs SHALL run independently; a read beat SHALL sample memory in its issue cycle, so a same-cycle write to that word is not visible to that beat.
Reset
REQ-043 On reset, both FSMs SHALL go idle and counters clear; awready=arready=1; wready, bvalid, rvalid, rlast, acvalid=0; IDs, data, resp, acaddr=0; acsnoop=4'hD; memory contents are retained; reset SHALL abort any burst in progress.
Structure
REQ-044 Burst, response, and snoop encodings SHALL live in shared package axi_pkg; byte-strobed storage SHALL be sub-module axi_mem_array (1 read port, 1 write port).
Verification
REQ-045 Write AW 0x40, awlen 7, data 0x11..0x88, wstrb 0xFF, bready=1 -> bresp 00, bid=awid, then acvalid with acaddr 0x40 and acsnoop 0xD.
REQ-046 WRAP read at 0x58, arlen 7 -> first rvalid exactly READ_LATENCY cycles after accept; beat data order is words at 0x58, 0x60..0x78, 0x40..0x50; rlast only on the 8th beat.
REQ-047 rready toggled 1-0-0-1 mid-burst -> rdata held stable while stalled; no beat lost or duplicated.
REQ-048 wstrb 0x0F of 0xFFFFFFFFFFFFFFFF over an existing word 0 -> read back 0x00000000FFFFFFFF; read at MEM_BYTES -> rresp SLVERR, rdata 0; reset asserted mid-read -> rvalid 0 the next cycle.

---
 rtl/axi_pkg.sv | 36 +++
 rtl/axi_mem_responder_if.sv | 48 ++++
 rtl/axi_mem_array.sv | 28 ++
 rtl/axi_mem_responder.sv | 189 ++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings (burst, response, snoop) and beat address helper
// for the memory responder.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  localparam logic [3:0] SNOOP_MAKE_INVALID = 4'hD;

  // Byte address of beat idx. len_bytes-1 = 8*len+7, so the wrap mask is {len, 3'b111}.
  // Any burst code other than WRAP is treated as INCR.
  function automatic logic [63:0] beat_addr(input logic [63:0] start,
                                            input logic [7:0]  len,
                                            input logic [1:0]  burst,
                                            input logic [7:0]  idx);
    logic [63:0] off;
    logic [63:0] mask;
    off  = {53'b0, idx, 3'b000};
    mask = {53'b0, len, 3'b111};
    if (burst == BURST_WRAP)
      beat_addr = (start & ~mask) | ((start + off) & mask);
    else
      beat_addr = start + off;
  endfunction

endpackage

// File: rtl/axi_mem_responder_if.sv
// AXI-style bus bundle (AW/W/B/AR/R plus AC snoop) between a master and
// the memory responder.
interface axi_mem_responder_if;
  logic [12:0] awid;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [12:0] bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [12:0] arid;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [12:0] rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        acvalid;
  logic        acready;
  logic [63:0] acaddr;
  logic [3:0]  acsnoop;

  modport master (
    output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arburst, arvalid, rready, acready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp,
           rlast, rvalid, acvalid, acaddr, acsnoop
  );

  modport slave (
    input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arburst, arvalid, rready, acready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp,
           rlast, rvalid, acvalid, acaddr, acsnoop
  );
endinterface

// File: rtl/axi_mem_array.sv
// Byte-strobed 64-bit word storage: one combinational read port, one
// synchronous write port. Contents are not reset.
module axi_mem_array #(
  parameter  int unsigned WORDS = 8192,
  localparam int unsigned IW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [7:0]    wstrb,
  input  logic [IW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI memory responder: independent read (INCR/WRAP, fixed latency) and
// write (INCR, B then MakeInvalid snoop) engines over a shared byte array.
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter int unsigned MEM_BYTES    = 65536,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic                clk,
  input  logic                reset,
  axi_mem_responder_if.slave  m_axi
);

  localparam int unsigned WORDS = MEM_BYTES / 8;
  localparam int unsigned IW    = $clog2(WORDS);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP, W_SNOOP} w_state_t;

  function automatic logic in_range(input logic [63:0] a);
    return a < 64'(MEM_BYTES);
  endfunction

  logic [63:0] mem_rdata;

  // ---------------- read engine ----------------
  r_state_t    r_state, r_next;
  logic [12:0] r_id;
  logic [63:0] r_start;
  logic [7:0]  r_len;
  logic [1:0]  r_burst;
  logic [7:0]  r_idx;
  logic [31:0] r_lat;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        r_issue;
  logic [63:0] iss_addr;
  logic [7:0]  iss_idx;
  logic [7:0]  iss_len;

  // A beat is "issued" in the cycle its data register loads; that is when memory is sampled.
  always_comb begin
    r_next   = r_state;
    r_issue  = 1'b0;
    iss_idx  = '0;
    iss_len  = r_len;
    iss_addr = r_start;
    case (r_state)
      R_IDLE: begin
        if (m_axi.arvalid) begin
          if (READ_LATENCY <= 1) begin
            r_next   = R_BURST;
            r_issue  = 1'b1;
            iss_len  = m_axi.arlen;
            iss_addr = m_axi.araddr;
          end else begin
            r_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_lat >= 32'(READ_LATENCY - 1)) begin
          r_next  = R_BURST;
          r_issue = 1'b1;
        end
      end
      R_BURST: begin
        if (m_axi.rready) begin
          if (r_idx == r_len) begin
            r_next = R_IDLE;
          end else begin
            r_issue  = 1'b1;
            iss_idx  = r_idx + 8'd1;
            iss_addr = beat_addr(r_start, r_len, r_burst, iss_idx);
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_start <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_idx   <= '0;
      r_lat   <= '0;
      r_data  <= '0;
      r_resp  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && m_axi.arvalid) begin
        r_id    <= m_axi.arid;
        r_start <= m_axi.araddr;
        r_len   <= m_axi.arlen;
        r_burst <= m_axi.arburst;
        r_idx   <= '0;
        r_lat   <= 32'd1;
      end else if (r_state == R_WAIT) begin
        r_lat <= r_lat + 32'd1;
      end
      if (r_state == R_BURST && m_axi.rready && r_idx != r_len) r_idx <= r_idx + 8'd1;
      if (r_issue) begin
        r_data <= in_range(iss_addr) ? mem_rdata : '0;
        r_resp <= in_range(iss_addr) ? RESP_OKAY : RESP_SLVERR;
        r_last <= (iss_idx == iss_len);
      end
    end
  end

  assign m_axi.arready = (r_state == R_IDLE);
  assign m_axi.rvalid  = (r_state == R_BURST);
  assign m_axi.rlast   = (r_state == R_BURST) && r_last;
  assign m_axi.rid     = r_id;
  assign m_axi.rdata   = r_data;
  assign m_axi.rresp   = r_resp;

  // ---------------- write engine ----------------
  w_state_t    w_state, w_next;
  logic [12:0] w_id;
  logic [63:0] w_start;
  logic [7:0]  w_idx;
  logic        w_err;
  logic [63:0] w_addr;
  logic        w_beat;
  logic        mem_we;

  assign w_addr = beat_addr(w_start, 8'd0, BURST_INCR, w_idx);
  assign w_beat = (w_state == W_DATA) && m_axi.wvalid;
  assign mem_we = w_beat && in_range(w_addr);

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (m_axi.awvalid)               w_next = W_DATA;
      W_DATA:  if (m_axi.wvalid && m_axi.wlast) w_next = W_RESP;
      W_RESP:  if (m_axi.bready)                w_next = W_SNOOP;
      W_SNOOP: if (m_axi.acready)               w_next = W_IDLE;
      default:                                  w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_start <= '0;
      w_idx   <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && m_axi.awvalid) begin
        w_id    <= m_axi.awid;
        w_start <= m_axi.awaddr;
        w_idx   <= '0;
        w_err   <= 1'b0;
      end
      if (w_beat) begin
        w_idx <= w_idx + 8'd1;
        if (!in_range(w_addr)) w_err <= 1'b1;
      end
    end
  end

  assign m_axi.awready = (w_state == W_IDLE);
  assign m_axi.wready  = (w_state == W_DATA);
  assign m_axi.bvalid  = (w_state == W_RESP);
  assign m_axi.bid     = w_id;
  assign m_axi.bresp   = w_err ? RESP_SLVERR : RESP_OKAY;
  assign m_axi.acvalid = (w_state == W_SNOOP);
  assign m_axi.acaddr  = {w_start[63:6], 6'b0};
  assign m_axi.acsnoop = SNOOP_MAKE_INVALID;

  axi_mem_array #(.WORDS(WORDS)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (w_addr[IW+2:3]),
    .wdata (m_axi.wdata),
    .wstrb (m_axi.wstrb),
    .raddr (iss_addr[IW+2:3]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: reset, write/snoop, WRAP and INCR
// reads, stalls, strobes, out-of-range, mid-read reset, back-to-back reads.
module tb_axi_mem_responder;
  import axi_pkg::*;

  localparam int unsigned MEM_BYTES    = 65536;
  localparam int unsigned READ_LATENCY = 4;

  localparam logic [63:0] PAT [8] = '{
    64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444,
    64'h5555555555555555, 64'h6666666666666666, 64'h7777777777777777, 64'h8888888888888888};
  localparam logic [63:0] EXP_WRAP [8] = '{
    64'h4444444444444444, 64'h5555555555555555, 64'h6666666666666666, 64'h7777777777777777,
    64'h8888888888888888, 64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axi_mem_responder_if m_axi();

  axi_mem_responder #(.MEM_BYTES(MEM_BYTES), .READ_LATENCY(READ_LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .m_axi (m_axi)
  );

  int tests = 0;
  int fails = 0;

  logic [63:0] wr_data [16];
  logic [1:0]  wr_bresp;
  logic [12:0] wr_bid;
  logic [63:0] wr_acaddr;
  logic [3:0]  wr_acsnoop;
  bit          wr_acseen;
  bit          wr_timeout;

  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic [15:0] rd_last;
  logic [12:0] rd_id;
  int          rd_beats, rd_lat, rd_stalls, rd_unstable;
  bit          rd_timeout;

  task automatic axi_write(input logic [12:0] id, input logic [63:0] addr, input int n,
                           input logic [7:0] strb);
    int guard;
    wr_timeout = 0; wr_acseen = 0; wr_bresp = '1; wr_bid = '1; wr_acaddr = '1; wr_acsnoop = '0;
    @(negedge clk);
    guard = 0;
    while (!m_axi.awready && guard < 50) begin @(negedge clk); guard++; end
    if (!m_axi.awready) begin wr_timeout = 1; return; end
    m_axi.awid = id; m_axi.awaddr = addr; m_axi.awlen = 8'(n - 1); m_axi.awvalid = 1'b1;
    @(negedge clk);
    m_axi.awvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      m_axi.wdata = wr_data[i]; m_axi.wstrb = strb; m_axi.wlast = (i == n - 1); m_axi.wvalid = 1'b1;
      guard = 0;
      while (!m_axi.wready && guard < 50) begin @(negedge clk); guard++; end
      if (!m_axi.wready) begin wr_timeout = 1; m_axi.wvalid = 1'b0; return; end
      @(negedge clk);
    end
    m_axi.wvalid = 1'b0; m_axi.wlast = 1'b0;
    guard = 0;
    while (!m_axi.bvalid && guard < 50) begin @(negedge clk); guard++; end
    if (!m_axi.bvalid) begin wr_timeout = 1; return; end
    wr_bresp = m_axi.bresp; wr_bid = m_axi.bid;
    @(negedge clk);
    guard = 0;
    while (!m_axi.acvalid && guard < 50) begin @(negedge clk); guard++; end
    if (!m_axi.acvalid) begin wr_timeout = 1; return; end
    wr_acseen = 1; wr_acaddr = m_axi.acaddr; wr_acsnoop = m_axi.acsnoop;
    @(negedge clk);
  endtask

  // stall_mask bit c drops rready in the c-th cycle after the first rvalid.
  task automatic axi_read(input logic [12:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [31:0] stall_mask);
    int guard;
    logic [63:0] held;
    bit stalled;
    rd_beats = 0; rd_stalls = 0; rd_unstable = 0; rd_last = '0; rd_timeout = 0; rd_lat = 0;
    rd_id = '1; stalled = 0; held = '0;
    @(negedge clk);
    guard = 0;
    while (!m_axi.arready && guard < 50) begin @(negedge clk); guard++; end
    if (!m_axi.arready) begin rd_timeout = 1; return; end
    m_axi.arid = id; m_axi.araddr = addr; m_axi.arlen = len; m_axi.arburst = burst;
    m_axi.arvalid = 1'b1;
    @(negedge clk);
    m_axi.arvalid = 1'b0;
    rd_lat = 1;
    while (!m_axi.rvalid && rd_lat < 50) begin @(negedge clk); rd_lat++; end
    if (!m_axi.rvalid) begin rd_timeout = 1; return; end
    for (int c = 0; c < 200 && rd_beats <= int'(len); c++) begin
      if (!m_axi.rvalid) begin rd_timeout = 1; break; end
      if (stalled && m_axi.rdata !== held) rd_unstable++;
      if (c < 32 && stall_mask[c]) begin
        m_axi.rready = 1'b0; held = m_axi.rdata; stalled = 1; rd_stalls++;
      end else begin
        m_axi.rready = 1'b1; stalled = 0;
        rd_data[rd_beats] = m_axi.rdata; rd_resp[rd_beats] = m_axi.rresp;
        rd_last[rd_beats] = m_axi.rlast; rd_id = m_axi.rid;
        rd_beats++;
      end
      @(negedge clk);
    end
    m_axi.rready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if ({m_axi.awready, m_axi.arready} !== 2'b11) begin
      fails++; $display("FAIL reset_ready: got %b required 11", {m_axi.awready, m_axi.arready}); end
    tests++; if ({m_axi.wready, m_axi.bvalid, m_axi.rvalid, m_axi.rlast, m_axi.acvalid} !== 5'b0) begin
      fails++; $display("FAIL reset_valids: got %b required 00000",
        {m_axi.wready, m_axi.bvalid, m_axi.rvalid, m_axi.rlast, m_axi.acvalid}); end
    tests++; if ({m_axi.bid, m_axi.bresp, m_axi.rid, m_axi.rresp} !== 30'h0) begin
      fails++; $display("FAIL reset_ids: got %h required 0", {m_axi.bid, m_axi.bresp, m_axi.rid, m_axi.rresp}); end
    tests++; if (m_axi.rdata !== 64'h0 || m_axi.acaddr !== 64'h0) begin
      fails++; $display("FAIL reset_data: rdata %h acaddr %h required 0", m_axi.rdata, m_axi.acaddr); end
    tests++; if (m_axi.acsnoop !== 4'hD) begin
      fails++; $display("FAIL reset_acsnoop: got %h required d", m_axi.acsnoop); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if ({m_axi.awready, m_axi.arready, m_axi.rvalid} !== 3'b110) begin
      fails++; $display("FAIL post_reset_idle: got %b required 110", {m_axi.awready, m_axi.arready, m_axi.rvalid}); end
  endtask

  task automatic test_write_burst();
    for (int i = 0; i < 8; i++) wr_data[i] = PAT[i];
    axi_write(13'h1ABC, 64'h40, 8, 8'hFF);
    tests++; if (wr_timeout || !wr_acseen) begin
      fails++; $display("FAIL wr_handshake: timeout %0d acseen %0d required 0/1", wr_timeout, wr_acseen); end
    tests++; if (wr_bresp !== 2'b00) begin fails++; $display("FAIL wr_bresp: got %b required 00", wr_bresp); end
    tests++; if (wr_bid !== 13'h1ABC) begin fails++; $display("FAIL wr_bid: got %h required 1abc", wr_bid); end
    tests++; if (wr_acaddr !== 64'h40) begin fails++; $display("FAIL wr_acaddr: got %h required 40", wr_acaddr); end
    tests++; if (wr_acsnoop !== 4'hD) begin fails++; $display("FAIL wr_acsnoop: got %h required d", wr_acsnoop); end
  endtask

  task automatic test_wrap_read();
    axi_read(13'h0F5, 64'h58, 8'd7, BURST_WRAP, 32'h0);
    tests++; if (rd_timeout || rd_beats != 8) begin
      fails++; $display("FAIL wrap_beats: got %0d (timeout %0d) required 8", rd_beats, rd_timeout); end
    tests++; if (rd_lat != READ_LATENCY) begin
      fails++; $display("FAIL wrap_latency: got %0d required %0d", rd_lat, READ_LATENCY); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (rd_data[i] !== EXP_WRAP[i] || rd_resp[i] !== 2'b00) begin
        fails++; $display("FAIL wrap_beat%0d: got %h/%b required %h/00", i, rd_data[i], rd_resp[i], EXP_WRAP[i]); end
    end
    tests++; if (rd_last !== 16'h0080) begin fails++; $display("FAIL wrap_rlast: got %h required 0080", rd_last); end
    tests++; if (rd_id !== 13'h0F5) begin fails++; $display("FAIL wrap_rid: got %h required 0f5", rd_id); end
    tests++; if (m_axi.rvalid !== 1'b0) begin fails++; $display("FAIL wrap_extra_beat: rvalid %b required 0", m_axi.rvalid); end
  endtask

  task automatic test_stall();
    axi_read(13'h022, 64'h40, 8'd7, BURST_INCR, 32'h18);
    tests++; if (rd_timeout || rd_beats != 8) begin
      fails++; $display("FAIL stall_beats: got %0d (timeout %0d) required 8", rd_beats, rd_timeout); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (rd_data[i] !== PAT[i]) begin
        fails++; $display("FAIL stall_beat%0d: got %h required %h", i, rd_data[i], PAT[i]); end
    end
    tests++; if (rd_stalls != 2 || rd_unstable != 0) begin
      fails++; $display("FAIL stall_hold: stalls %0d unstable %0d required 2/0", rd_stalls, rd_unstable); end
    tests++; if (rd_last !== 16'h0080 || m_axi.rvalid !== 1'b0) begin
      fails++; $display("FAIL stall_rlast: got %h rvalid %b required 0080/0", rd_last, m_axi.rvalid); end
  endtask

  task automatic test_strobe();
    wr_data[0] = 64'h0;
    axi_write(13'h001, 64'h0, 1, 8'hFF);
    wr_data[0] = 64'hFFFFFFFFFFFFFFFF;
    axi_write(13'h002, 64'h0, 1, 8'h0F);
    tests++; if (wr_timeout || wr_bresp !== 2'b00) begin
      fails++; $display("FAIL strb_bresp: got %b (timeout %0d) required 00", wr_bresp, wr_timeout); end
    axi_read(13'h003, 64'h0, 8'd0, BURST_INCR, 32'h0);
    tests++; if (rd_data[0] !== 64'h00000000FFFFFFFF || rd_resp[0] !== 2'b00 || rd_beats != 1) begin
      fails++; $display("FAIL strb_readback: got %h/%b beats %0d required 00000000ffffffff/00/1",
        rd_data[0], rd_resp[0], rd_beats); end
    tests++; if (rd_last !== 16'h0001) begin fails++; $display("FAIL strb_rlast: got %h required 0001", rd_last); end
    wr_data[0] = 64'hDEADBEEFCAFEF00D;
    axi_write(13'h004, 64'h4568, 1, 8'hFF);
    tests++; if (wr_acaddr !== 64'h4540) begin fails++; $display("FAIL line_acaddr: got %h required 4540", wr_acaddr); end
    axi_read(13'h005, 64'h456F, 8'd0, BURST_INCR, 32'h0);
    tests++; if (rd_data[0] !== 64'hDEADBEEFCAFEF00D) begin
      fails++; $display("FAIL lowbits_ignored: got %h required deadbeefcafef00d", rd_data[0]); end
  endtask

  task automatic test_out_of_range();
    axi_read(13'h006, 64'(MEM_BYTES), 8'd0, BURST_INCR, 32'h0);
    tests++; if (rd_data[0] !== 64'h0 || rd_resp[0] !== 2'b10 || rd_beats != 1) begin
      fails++; $display("FAIL oor_read: got %h/%b beats %0d required 0/10/1", rd_data[0], rd_resp[0], rd_beats); end
    wr_data[0] = 64'h1234567812345678;
    axi_write(13'h007, 64'(MEM_BYTES), 1, 8'hFF);
    tests++; if (wr_bresp !== 2'b10 || wr_bid !== 13'h007) begin
      fails++; $display("FAIL oor_write: bresp %b bid %h required 10/007", wr_bresp, wr_bid); end
    wr_data[0] = 64'hA5A5A5A5A5A5A5A5;
    wr_data[1] = 64'h5A5A5A5A5A5A5A5A;
    axi_write(13'h008, 64'(MEM_BYTES - 8), 2, 8'hFF);
    tests++; if (wr_bresp !== 2'b10 || wr_acaddr !== 64'hFFC0) begin
      fails++; $display("FAIL cross_write: bresp %b acaddr %h required 10/ffc0", wr_bresp, wr_acaddr); end
    axi_read(13'h009, 64'(MEM_BYTES - 8), 8'd1, BURST_INCR, 32'h0);
    tests++; if (rd_data[0] !== 64'hA5A5A5A5A5A5A5A5 || rd_resp[0] !== 2'b00) begin
      fails++; $display("FAIL cross_read0: got %h/%b required a5a5a5a5a5a5a5a5/00", rd_data[0], rd_resp[0]); end
    tests++; if (rd_data[1] !== 64'h0 || rd_resp[1] !== 2'b10 || rd_last !== 16'h0002) begin
      fails++; $display("FAIL cross_read1: got %h/%b last %h required 0/10/0002", rd_data[1], rd_resp[1], rd_last); end
    axi_read(13'h00A, 64'h0, 8'd0, BURST_INCR, 32'h0);
    tests++; if (rd_data[0] !== 64'h00000000FFFFFFFF) begin
      fails++; $display("FAIL no_alias: word0 %h required 00000000ffffffff", rd_data[0]); end
  endtask

  task automatic test_reset_mid_read();
    int guard;
    @(negedge clk);
    m_axi.arid = 13'h0AA; m_axi.araddr = 64'h40; m_axi.arlen = 8'd7; m_axi.arburst = BURST_INCR;
    m_axi.arvalid = 1'b1;
    @(negedge clk);
    m_axi.arvalid = 1'b0;
    guard = 0;
    while (!m_axi.rvalid && guard < 50) begin @(negedge clk); guard++; end
    tests++; if (m_axi.rvalid !== 1'b1) begin fails++; $display("FAIL midrst_start: rvalid %b required 1", m_axi.rvalid); end
    m_axi.rready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++; if ({m_axi.rvalid, m_axi.rlast, m_axi.arready} !== 3'b001) begin
      fails++; $display("FAIL midrst_abort: rvalid/rlast/arready %b required 001",
        {m_axi.rvalid, m_axi.rlast, m_axi.arready}); end
    reset = 1'b0;
    m_axi.rready = 1'b0;
    @(negedge clk);
    tests++; if (m_axi.rvalid !== 1'b0) begin fails++; $display("FAIL midrst_stay_idle: rvalid %b required 0", m_axi.rvalid); end
  endtask

  task automatic test_back_to_back();
    axi_read(13'h101, 64'h60, 8'd1, BURST_INCR, 32'h0);
    tests++; if (rd_beats != 2 || rd_data[0] !== PAT[4] || rd_data[1] !== PAT[5] || rd_lat != READ_LATENCY) begin
      fails++; $display("FAIL b2b_first: beats %0d data %h %h lat %0d required 2 %h %h %0d",
        rd_beats, rd_data[0], rd_data[1], rd_lat, PAT[4], PAT[5], READ_LATENCY); end
    axi_read(13'h102, 64'h70, 8'd1, BURST_INCR, 32'h0);
    tests++; if (rd_beats != 2 || rd_data[0] !== PAT[6] || rd_data[1] !== PAT[7] || rd_id !== 13'h102) begin
      fails++; $display("FAIL b2b_second: beats %0d data %h %h rid %h required 2 %h %h 102",
        rd_beats, rd_data[0], rd_data[1], rd_id, PAT[6], PAT[7]); end
  endtask

  initial begin
    m_axi.awid = '0; m_axi.awaddr = '0; m_axi.awlen = '0; m_axi.awvalid = 1'b0;
    m_axi.wdata = '0; m_axi.wstrb = '0; m_axi.wlast = 1'b0; m_axi.wvalid = 1'b0;
    m_axi.bready = 1'b1;
    m_axi.arid = '0; m_axi.araddr = '0; m_axi.arlen = '0; m_axi.arburst = '0; m_axi.arvalid = 1'b0;
    m_axi.rready = 1'b0;
    m_axi.acready = 1'b1;
    test_reset();
    test_write_burst();
    test_wrap_read();
    test_stall();
    test_strobe();
    test_out_of_range();
    test_reset_mid_read();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
